// File: rtl/gshare_predictor_if.sv
// Lookup/update port bundle for gshare_predictor.
// Fetch drives the lookup side and execute drives the update side through the master modport.
interface gshare_predictor_if #(
    parameter int BPRED_WIDTH = 10
);
    logic                   i_Lookup_Valid;
    logic [31:0]            i_Lookup_PC;
    logic                   o_Pred_Valid;
    logic                   o_Pred_Taken;
    logic [BPRED_WIDTH-1:0] o_Pred_Index;
    logic                   i_Update_Valid;
    logic [BPRED_WIDTH-1:0] i_Update_Index;
    logic                   i_Update_Outcome;
    logic                   i_Update_Mispredict;
    logic                   o_Ready;

    modport master (
        output i_Lookup_Valid, i_Lookup_PC,
        output i_Update_Valid, i_Update_Index, i_Update_Outcome, i_Update_Mispredict,
        input  o_Pred_Valid, o_Pred_Taken, o_Pred_Index, o_Ready
    );

    modport slave (
        input  i_Lookup_Valid, i_Lookup_PC,
        input  i_Update_Valid, i_Update_Index, i_Update_Outcome, i_Update_Mispredict,
        output o_Pred_Valid, o_Pred_Taken, o_Pred_Index, o_Ready
    );
endinterface

// File: rtl/gshare_predictor.sv
// Gshare branch predictor: saturating counters indexed by PC XOR speculative history,
// with a committed history for mispredict repair and a sequential table-init sweep.
module gshare_predictor #(
    parameter int BPRED_WIDTH = 10,
    parameter int CTR_WIDTH   = 2,
    parameter int GHR_WIDTH   = 10
) (
    input  logic                i_Clk,
    input  logic                i_Reset,
    input  logic                i_Clear,
    gshare_predictor_if.slave   bus
);
    localparam int ENTRIES = 1 << BPRED_WIDTH;
    localparam logic [CTR_WIDTH-1:0]   CTR_MAX  = {CTR_WIDTH{1'b1}};
    localparam logic [CTR_WIDTH-1:0]   CTR_ZERO = {CTR_WIDTH{1'b0}};
    localparam logic [CTR_WIDTH-1:0]   CTR_WT   = ~(CTR_MAX >> 1);
    localparam logic [BPRED_WIDTH-1:0] PTR_LAST = {BPRED_WIDTH{1'b1}};
    localparam logic [BPRED_WIDTH-1:0] PTR_ZERO = {BPRED_WIDTH{1'b0}};
    localparam logic [GHR_WIDTH-1:0]   GHR_ZERO = {GHR_WIDTH{1'b0}};

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                 state_r, state_s;
    logic [BPRED_WIDTH-1:0] ptr_r, ptr_s;
    logic [GHR_WIDTH-1:0]   spec_ghr_r, spec_ghr_s;
    logic [GHR_WIDTH-1:0]   commit_ghr_r, commit_ghr_s;
    logic [CTR_WIDTH-1:0]   table_r [ENTRIES];

    logic                   ready_s, lookup_acc_s, update_acc_s, pred_s;
    logic [BPRED_WIDTH-1:0] lookup_idx_s;
    logic [CTR_WIDTH-1:0]   upd_old_s, upd_new_s, lookup_ctr_s;

    logic                   pred_valid_r, pred_taken_r, ready_r;
    logic [BPRED_WIDTH-1:0] pred_index_r;

    // Shift a history bit in; the truncating cast also covers a 1-bit history.
    function automatic logic [GHR_WIDTH-1:0] ghr_shift(input logic [GHR_WIDTH-1:0] ghr,
                                                       input logic bit_in);
        return GHR_WIDTH'({ghr, bit_in});
    endfunction

    assign ready_s      = (state_r == ST_READY);
    assign lookup_acc_s = ready_s & bus.i_Lookup_Valid;
    assign update_acc_s = ready_s & bus.i_Update_Valid;
    assign lookup_idx_s = bus.i_Lookup_PC[BPRED_WIDTH+1:2] ^ BPRED_WIDTH'(spec_ghr_r);
    assign upd_old_s    = table_r[bus.i_Update_Index];
    assign pred_s       = lookup_ctr_s[CTR_WIDTH-1];

    // Saturating counter step and same-cycle write bypass for the lookup
    always_comb begin
        upd_new_s    = upd_old_s;
        lookup_ctr_s = table_r[lookup_idx_s];
        if (bus.i_Update_Outcome) begin
            upd_new_s = (upd_old_s == CTR_MAX) ? upd_old_s : upd_old_s + CTR_WIDTH'(1);
        end else begin
            upd_new_s = (upd_old_s == CTR_ZERO) ? upd_old_s : upd_old_s - CTR_WIDTH'(1);
        end
        if (update_acc_s && (bus.i_Update_Index == lookup_idx_s)) begin
            lookup_ctr_s = upd_new_s;
        end else begin
            lookup_ctr_s = table_r[lookup_idx_s];
        end
    end

    // Next-state: init sweep, history tracking, mispredict repair and clear
    always_comb begin
        state_s      = state_r;
        ptr_s        = ptr_r;
        spec_ghr_s   = spec_ghr_r;
        commit_ghr_s = commit_ghr_r;
        case (state_r)
            ST_INIT: begin
                ptr_s = ptr_r + BPRED_WIDTH'(1);
                if (ptr_r == PTR_LAST) begin
                    state_s = ST_READY;
                end else begin
                    state_s = ST_INIT;
                end
            end
            ST_READY: begin
                if (lookup_acc_s) begin
                    spec_ghr_s = ghr_shift(spec_ghr_r, pred_s);
                end else begin
                    spec_ghr_s = spec_ghr_r;
                end
                if (update_acc_s) begin
                    commit_ghr_s = ghr_shift(commit_ghr_r, bus.i_Update_Outcome);
                    if (bus.i_Update_Mispredict) begin
                        spec_ghr_s = ghr_shift(commit_ghr_r, bus.i_Update_Outcome);
                    end else begin
                        spec_ghr_s = spec_ghr_s;
                    end
                end else begin
                    commit_ghr_s = commit_ghr_r;
                end
                if (i_Clear) begin
                    state_s      = ST_INIT;
                    ptr_s        = PTR_ZERO;
                    spec_ghr_s   = GHR_ZERO;
                    commit_ghr_s = GHR_ZERO;
                end else begin
                    state_s = ST_READY;
                end
            end
            default: begin
                state_s      = ST_INIT;
                ptr_s        = PTR_ZERO;
                spec_ghr_s   = GHR_ZERO;
                commit_ghr_s = GHR_ZERO;
            end
        endcase
    end

    // FSM, init pointer and history registers
    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            state_r      <= ST_INIT;
            ptr_r        <= PTR_ZERO;
            spec_ghr_r   <= GHR_ZERO;
            commit_ghr_r <= GHR_ZERO;
        end else begin
            state_r      <= state_s;
            ptr_r        <= ptr_s;
            spec_ghr_r   <= spec_ghr_s;
            commit_ghr_r <= commit_ghr_s;
        end
    end

    // Counter table has no reset; the INIT sweep is what makes it valid
    always_ff @(posedge i_Clk) begin
        if (state_r == ST_INIT) begin
            table_r[ptr_r] <= CTR_WT;
        end else if (update_acc_s) begin
            table_r[bus.i_Update_Index] <= upd_new_s;
        end
    end

    // Registered prediction and ready outputs
    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            pred_valid_r <= 1'b0;
            pred_taken_r <= 1'b0;
            pred_index_r <= PTR_ZERO;
            ready_r      <= 1'b0;
        end else begin
            pred_valid_r <= lookup_acc_s;
            ready_r      <= (state_s == ST_READY);
            if (lookup_acc_s) begin
                pred_taken_r <= pred_s;
                pred_index_r <= lookup_idx_s;
            end
        end
    end

    assign bus.o_Pred_Valid = pred_valid_r;
    assign bus.o_Pred_Taken = pred_taken_r;
    assign bus.o_Pred_Index = pred_index_r;
    assign bus.o_Ready      = ready_r;
endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor with BPRED_WIDTH=4, CTR_WIDTH=2, GHR_WIDTH=4.
module tb_gshare_predictor;
    localparam int BW = 4;
    localparam int CW = 2;
    localparam int GW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    int   errors = 0;
    int   checks = 0;

    gshare_predictor_if #(.BPRED_WIDTH(BW)) bus ();

    gshare_predictor #(.BPRED_WIDTH(BW), .CTR_WIDTH(CW), .GHR_WIDTH(GW)) dut (
        .i_Clk   (clk),
        .i_Reset (rst_n),
        .i_Clear (clear),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        bus.i_Lookup_Valid      = 1'b0;
        bus.i_Lookup_PC         = 32'h0;
        bus.i_Update_Valid      = 1'b0;
        bus.i_Update_Index      = 4'd0;
        bus.i_Update_Outcome    = 1'b0;
        bus.i_Update_Mispredict = 1'b0;
    endtask

    // One cycle of optional lookup and optional update, then back to idle
    task automatic drive(input logic lv, input logic [31:0] pc, input logic uv,
                         input logic [BW-1:0] ui, input logic uo, input logic um);
        bus.i_Lookup_Valid      = lv;
        bus.i_Lookup_PC         = pc;
        bus.i_Update_Valid      = uv;
        bus.i_Update_Index      = ui;
        bus.i_Update_Outcome    = uo;
        bus.i_Update_Mispredict = um;
        step();
        idle();
    endtask

    task automatic reinit;
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (16) step();
    endtask

    task automatic test_reset;
        logic [6:0] got;
        idle();
        rst_n = 1'b0;
        repeat (3) step();
        got = {bus.o_Ready, bus.o_Pred_Valid, bus.o_Pred_Taken, bus.o_Pred_Index};
        checks++;
        if (got !== 7'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", got, 7'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bus.o_Ready !== 1'b0) begin
                errors++;
                $display("FAIL init_ready_low cycle %0d: got %b expected 0", i, bus.o_Ready);
            end
            step();
        end
        checks++;
        if (bus.o_Ready !== 1'b1) begin
            errors++;
            $display("FAIL init_ready_high: got %b expected 1", bus.o_Ready);
        end
        drive(1'b1, 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
        got = {1'b0, bus.o_Pred_Valid, bus.o_Pred_Taken, bus.o_Pred_Index};
        checks++;
        if (got !== {1'b0, 1'b1, 1'b1, 4'd0}) begin
            errors++;
            $display("FAIL first_lookup: got %b expected %b", got, {1'b0, 1'b1, 1'b1, 4'd0});
        end
        step();
        checks++;
        if (bus.o_Pred_Valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_pulse: got %b expected 0", bus.o_Pred_Valid);
        end
    endtask

    task automatic test_saturation;
        logic [5:0] got;
        reinit();
        repeat (2) drive(1'b0, 32'h0, 1'b1, 4'd5, 1'b0, 1'b0);
        drive(1'b1, 32'h14, 1'b0, 4'd0, 1'b0, 1'b0);
        got = {bus.o_Pred_Valid, bus.o_Pred_Taken, bus.o_Pred_Index};
        checks++;
        if (got !== {1'b1, 1'b0, 4'd5}) begin
            errors++;
            $display("FAIL sat_low_pred: got %b expected %b", got, {1'b1, 1'b0, 4'd5});
        end
        repeat (5) drive(1'b0, 32'h0, 1'b1, 4'd5, 1'b1, 1'b0);
        drive(1'b1, 32'h14, 1'b0, 4'd0, 1'b0, 1'b0);
        got = {bus.o_Pred_Valid, bus.o_Pred_Taken, bus.o_Pred_Index};
        checks++;
        if (got !== {1'b1, 1'b1, 4'd5}) begin
            errors++;
            $display("FAIL sat_high_pred: got %b expected %b", got, {1'b1, 1'b1, 4'd5});
        end
        // S is now 0001, so PC index 4 hashes to table entry 5 (counter 3 -> 2)
        drive(1'b0, 32'h0, 1'b1, 4'd5, 1'b0, 1'b0);
        drive(1'b1, 32'h10, 1'b0, 4'd0, 1'b0, 1'b0);
        got = {bus.o_Pred_Valid, bus.o_Pred_Taken, bus.o_Pred_Index};
        checks++;
        if (got !== {1'b1, 1'b1, 4'd5}) begin
            errors++;
            $display("FAIL sat_no_wrap: got %b expected %b", got, {1'b1, 1'b1, 4'd5});
        end
    endtask

    task automatic test_back_to_back_and_repair;
        logic [5:0] got;
        logic [3:0] exp_idx [3];
        exp_idx[0] = 4'd0;
        exp_idx[1] = 4'd1;
        exp_idx[2] = 4'd3;
        reinit();
        bus.i_Lookup_Valid = 1'b1;
        bus.i_Lookup_PC    = 32'h0;
        for (int i = 0; i < 3; i++) begin
            step();
            got = {bus.o_Pred_Valid, bus.o_Pred_Taken, bus.o_Pred_Index};
            checks++;
            if (got !== {1'b1, 1'b1, exp_idx[i]}) begin
                errors++;
                $display("FAIL b2b_lookup %0d: got %b expected %b", i, got, {1'b1, 1'b1, exp_idx[i]});
            end
        end
        idle();
        drive(1'b0, 32'h0, 1'b1, 4'd9, 1'b0, 1'b1);
        drive(1'b1, 32'h1C, 1'b0, 4'd0, 1'b0, 1'b0);
        got = {bus.o_Pred_Valid, bus.o_Pred_Taken, bus.o_Pred_Index};
        checks++;
        if (got !== {1'b1, 1'b1, 4'd7}) begin
            errors++;
            $display("FAIL repair_index: got %b expected %b", got, {1'b1, 1'b1, 4'd7});
        end
        // Lookup with old S=0001 plus mispredict: S must end at {C[2:0],1} = 0001
        drive(1'b1, 32'h1C, 1'b1, 4'd10, 1'b1, 1'b1);
        got = {bus.o_Pred_Valid, bus.o_Pred_Taken, bus.o_Pred_Index};
        checks++;
        if (got !== {1'b1, 1'b1, 4'd6}) begin
            errors++;
            $display("FAIL same_cycle_misp_lookup: got %b expected %b", got, {1'b1, 1'b1, 4'd6});
        end
        drive(1'b1, 32'h1C, 1'b0, 4'd0, 1'b0, 1'b0);
        got = {bus.o_Pred_Valid, bus.o_Pred_Taken, bus.o_Pred_Index};
        checks++;
        if (got !== {1'b1, 1'b1, 4'd6}) begin
            errors++;
            $display("FAIL repair_overrides_shift: got %b expected %b", got, {1'b1, 1'b1, 4'd6});
        end
    endtask

    task automatic test_bypass;
        logic [5:0] got;
        reinit();
        drive(1'b1, 32'h0C, 1'b1, 4'd3, 1'b0, 1'b0);
        got = {bus.o_Pred_Valid, bus.o_Pred_Taken, bus.o_Pred_Index};
        checks++;
        if (got !== {1'b1, 1'b0, 4'd3}) begin
            errors++;
            $display("FAIL bypass: got %b expected %b", got, {1'b1, 1'b0, 4'd3});
        end
        drive(1'b1, 32'h14, 1'b0, 4'd0, 1'b0, 1'b0);
        got = {bus.o_Pred_Valid, bus.o_Pred_Taken, bus.o_Pred_Index};
        checks++;
        if (got !== {1'b1, 1'b1, 4'd5}) begin
            errors++;
            $display("FAIL post_bypass_lookup: got %b expected %b", got, {1'b1, 1'b1, 4'd5});
        end
    endtask

    task automatic test_reset_mid_init;
        logic [6:0] got;
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (7) step();
        got = {bus.o_Ready, bus.o_Pred_Valid, bus.o_Pred_Taken, bus.o_Pred_Index};
        checks++;
        if (got !== {1'b0, 1'b0, 1'b1, 4'd5}) begin
            errors++;
            $display("FAIL init_holds_outputs: got %b expected %b", got, {1'b0, 1'b0, 1'b1, 4'd5});
        end
        rst_n = 1'b0;
        #1;
        got = {bus.o_Ready, bus.o_Pred_Valid, bus.o_Pred_Taken, bus.o_Pred_Index};
        checks++;
        if (got !== 7'd0) begin
            errors++;
            $display("FAIL async_reset: got %b expected %b", got, 7'd0);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bus.o_Ready !== 1'b0) begin
                errors++;
                $display("FAIL reinit_ready_low cycle %0d: got %b expected 0", i, bus.o_Ready);
            end
            step();
        end
        checks++;
        if (bus.o_Ready !== 1'b1) begin
            errors++;
            $display("FAIL reinit_ready_high: got %b expected 1", bus.o_Ready);
        end
    endtask

    task automatic test_clear;
        logic [5:0] got;
        reinit();
        repeat (2) drive(1'b0, 32'h0, 1'b1, 4'd2, 1'b0, 1'b0);
        drive(1'b1, 32'h08, 1'b0, 4'd0, 1'b0, 1'b0);
        got = {bus.o_Pred_Valid, bus.o_Pred_Taken, bus.o_Pred_Index};
        checks++;
        if (got !== {1'b1, 1'b0, 4'd2}) begin
            errors++;
            $display("FAIL pre_clear_pred: got %b expected %b", got, {1'b1, 1'b0, 4'd2});
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        bus.i_Lookup_Valid = 1'b1;
        bus.i_Lookup_PC    = 32'h08;
        bus.i_Update_Valid = 1'b1;
        bus.i_Update_Index = 4'd2;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if ({bus.o_Ready, bus.o_Pred_Valid} !== 2'b00) begin
                errors++;
                $display("FAIL clear_init_ignored cycle %0d: got %b expected 00", i,
                         {bus.o_Ready, bus.o_Pred_Valid});
            end
            step();
        end
        idle();
        checks++;
        if (bus.o_Ready !== 1'b1) begin
            errors++;
            $display("FAIL clear_ready_high: got %b expected 1", bus.o_Ready);
        end
        drive(1'b1, 32'h08, 1'b0, 4'd0, 1'b0, 1'b0);
        got = {bus.o_Pred_Valid, bus.o_Pred_Taken, bus.o_Pred_Index};
        checks++;
        if (got !== {1'b1, 1'b1, 4'd2}) begin
            errors++;
            $display("FAIL post_clear_pred: got %b expected %b", got, {1'b1, 1'b1, 4'd2});
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_saturation();
        test_back_to_back_and_repair();
        test_bypass();
        test_reset_mid_init();
        test_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
